instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Two-byte instruction fetch stage for the 8-bit accumulator CPU. Reads the opcode byte (IRA) and operand byte (IRB) from the synchronous single-port RAM and advances an internal PC. Presents each completed instruction to the decode/execute stage over a valid/ready handshake. Accepts PC redirects from execute for jump, skip, return and jump-with-link.

## Interface
- `ADDR_WIDTH`, default 8: PC and RAM address width.
- `DATA_WIDTH`, default 8: RAM word width, and the width of each instruction byte.
- `RESET_PC`, default 'h00: PC value loaded on reset.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `fetch_en`: input, 1 bit. When low, no new instruction fetch starts. Used for halt and for program-load.
- `mem_addr`: output, ADDR_WIDTH. RAM address.
- `mem_re`: output, 1 bit. RAM read strobe. Drives the RAM's cs/oe; we is held 0 by the top level.
- `mem_rdata`: input, DATA_WIDTH. RAM read data.
- `inst_valid`: output, 1 bit. An instruction is presented to decode.
- `inst_ready`: input, 1 bit. Decode accepts the presented instruction.
- `inst_op`: output, DATA_WIDTH. Opcode byte (IRA).
- `inst_arg`: output, DATA_WIDTH. Operand byte (IRB).
- `inst_pc`: output, ADDR_WIDTH. Address of the opcode byte.
- `redirect_valid`: input, 1 bit. Execute requests a PC change.
- `redirect_pc`: input, ADDR_WIDTH. New PC value.

## Operation
- States:
  - `A_REQ`: mem_addr=pc, mem_re=1.
  - `A_WAIT`: mem_re=0; at the end of this cycle, op_reg <= mem_rdata and pc <= pc+1.
  - `B_REQ`: mem_addr=pc, mem_re=1.
  - `B_WAIT`: at the end of this cycle, arg_reg <= mem_rdata and pc <= pc+1.
  - `PRESENT`: inst_valid=1.
- The RAM has a registered output. The address is sampled at the edge ending a `*_REQ` cycle. Data is valid during the following `*_WAIT` cycle and is captured at the edge ending it.
- `mem_addr` and `mem_re` are Moore outputs of the state register. `mem_addr` holds pc in all states.
- PC arithmetic is modulo 2^ADDR_WIDTH: 'hFF+1 wraps to 'h00. Odd PCs are legal; there is no alignment check.
- Transitions:
  - `A_REQ`→`A_WAIT`→`B_REQ`→`B_WAIT`→`PRESENT` unconditionally.
  - `PRESENT` with inst_ready=1: go to `A_REQ` if fetch_en=1, else to `IDLE`.
  - `IDLE`: inst_valid=0, mem_re=0. Go to `A_REQ` when fetch_en=1.
- fetch_en=0 does not abort a fetch in progress. That fetch completes to `PRESENT`.
- inst_op, inst_arg and inst_pc are stable while inst_valid=1 and inst_ready=0.
- Redirect:
  - When redirect_valid=1 at an edge, in any state: pc <= redirect_pc, inst_valid <= 0, and the next state is `A_REQ` (or `IDLE` if fetch_en=0).
  - Read data still in flight from the RAM is discarded.
  - Redirect takes priority over inst_ready in the same cycle.
- Reset values:
  - pc=RESET_PC, state=`IDLE`.
  - inst_valid=0, mem_re=0, mem_addr=RESET_PC.
  - inst_op=0, inst_arg=0, inst_pc=RESET_PC.

## Timing
- With fetch_en=1 after reset: `A_REQ` is entered at edge 1 and inst_valid rises after edge 5. Latency from the first request is 4 cycles.
- Without prefetch, sustained throughput is 1 instruction per 5 cycles when inst_ready is held high.
- Redirect asserted at edge N: the `A_REQ` for redirect_pc is on the cycle after edge N. The first post-redirect inst_valid rises after edge N+4.
- inst_pc is the pc value sampled at `A_REQ` of that instruction.

## Configuration
- `FETCH_PREFETCH_EN`
  - Defined: adds a one-entry holding register.
    - While in `PRESENT` with fetch_en=1, the FSM continues fetching the next instruction into the holding register.
    - On acceptance, the holding register moves to the outputs in the same edge if it is full.
    - If the holding register is full and the current instruction has not been accepted, the FSM stalls in `A_REQ` with mem_re=0.
    - Sustained throughput is 1 instruction per 4 cycles.
    - Redirect clears the holding register.
  - Undefined: no holding register and no fetch during `PRESENT`. Behaviour is exactly as described above.

## Test plan
- Reset and first fetch:
  - Stimulus: rst released, fetch_en=1, RAM[0]='h10, RAM[1]='h1C, inst_ready=1.
  - Response: inst_valid high after edge 5 with op='h10, arg='h1C, inst_pc='h00. Second instruction has inst_pc='h02.
- Backpressure:
  - Stimulus: hold inst_ready=0 for 10 cycles.
  - Response: outputs stable, mem_re=0 throughout (macro undefined). Accept on release; next inst_pc=current+2.
- Redirect:
  - Stimulus: redirect_valid=1 with redirect_pc='h00 during `B_WAIT` of the instruction at 'h18 (jump 'h90,'h00).
  - Response: no instruction from 'h1A is presented. The next inst_pc='h00.
- Wrap-around:
  - Stimulus: redirect_pc='hFE, RAM[FE]='h70, RAM[FF]='h00.
  - Response: op='h70, arg='h00. The next fetch address is 'h00.
- Halt:
  - Stimulus: fetch_en dropped during `A_WAIT`.
  - Response: the current instruction is still presented, then `IDLE` with mem_re=0. Re-raising fetch_en resumes at pc+2.
- Reset mid-fetch:
  - Stimulus: assert rst during `B_WAIT`.
  - Response: inst_valid=0, mem_re=0 and pc=RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Two-byte instruction fetch stage: reads opcode/operand from a registered-output RAM and hands them to decode.
// Optional one-entry prefetch holding register enabled by defining FETCH_PREFETCH_EN.
module instr_fetch_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_op,
  output logic [DATA_WIDTH-1:0] inst_arg,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
);
  // state   | meaning
  // IDLE    | fetch disabled, nothing in flight
  // A_REQ   | opcode address presented to RAM
  // A_WAIT  | opcode returning from RAM
  // B_REQ   | operand address presented to RAM
  // B_WAIT  | operand returning from RAM
  // PRESENT | instruction offered to decode
  typedef enum logic [2:0] {IDLE, A_REQ, A_WAIT, B_REQ, B_WAIT, PRESENT} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   pc;
  logic [ADDR_WIDTH-1:0]   fetch_pc;
  logic [DATA_WIDTH-1:0]   fetch_op;
  logic [DATA_WIDTH-1:0]   out_op, out_arg;
  logic [ADDR_WIDTH-1:0]   out_pc;

`ifdef FETCH_PREFETCH_EN
  logic                    out_valid;
  logic                    hold_full;
  logic [DATA_WIDTH-1:0]   hold_op, hold_arg;
  logic [ADDR_WIDTH-1:0]   hold_pc;

  assign inst_valid = out_valid;
  // A full holding register blocks the next opcode request until decode drains it.
  assign mem_re     = (state == A_REQ && !hold_full) || (state == B_REQ);
`else
  assign inst_valid = (state == PRESENT);
  assign mem_re     = (state == A_REQ) || (state == B_REQ);
`endif

  assign mem_addr = pc;
  assign inst_op  = out_op;
  assign inst_arg = out_arg;
  assign inst_pc  = out_pc;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fetch_en) state_nxt = A_REQ;
`ifdef FETCH_PREFETCH_EN
      A_REQ: begin
        if (!hold_full)     state_nxt = A_WAIT;
        else if (!fetch_en) state_nxt = PRESENT;
      end
`else
      A_REQ:   state_nxt = A_WAIT;
`endif
      A_WAIT:  state_nxt = B_REQ;
      B_REQ:   state_nxt = B_WAIT;
`ifdef FETCH_PREFETCH_EN
      B_WAIT:  state_nxt = fetch_en ? A_REQ : PRESENT;
      PRESENT: begin
        if (fetch_en)                                   state_nxt = A_REQ;
        else if (out_valid && inst_ready && !hold_full) state_nxt = IDLE;
      end
`else
      B_WAIT:  state_nxt = PRESENT;
      PRESENT: if (inst_ready) state_nxt = fetch_en ? A_REQ : IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
    if (redirect_valid) state_nxt = fetch_en ? A_REQ : IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      fetch_pc <= RESET_PC;
      fetch_op <= '0;
      out_op   <= '0;
      out_arg  <= '0;
      out_pc   <= RESET_PC;
`ifdef FETCH_PREFETCH_EN
      out_valid <= 1'b0;
      hold_full <= 1'b0;
      hold_op   <= '0;
      hold_arg  <= '0;
      hold_pc   <= RESET_PC;
`endif
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        // Any RAM data still in flight is simply never captured.
        pc <= redirect_pc;
`ifdef FETCH_PREFETCH_EN
        out_valid <= 1'b0;
        hold_full <= 1'b0;
`endif
      end else begin
        case (state)
          A_REQ:   if (mem_re) fetch_pc <= pc;
          A_WAIT: begin
            fetch_op <= mem_rdata;
            pc       <= pc + ADDR_WIDTH'(1);
          end
          B_WAIT:  pc <= pc + ADDR_WIDTH'(1);
          default: ;
        endcase
`ifdef FETCH_PREFETCH_EN
        if (state == B_WAIT) begin
          if (!out_valid || inst_ready) begin
            out_op    <= fetch_op;
            out_arg   <= mem_rdata;
            out_pc    <= fetch_pc;
            out_valid <= 1'b1;
          end else begin
            hold_op   <= fetch_op;
            hold_arg  <= mem_rdata;
            hold_pc   <= fetch_pc;
            hold_full <= 1'b1;
          end
        end else if (out_valid && inst_ready) begin
          if (hold_full) begin
            out_op    <= hold_op;
            out_arg   <= hold_arg;
            out_pc    <= hold_pc;
            hold_full <= 1'b0;
          end else begin
            out_valid <= 1'b0;
          end
        end
`else
        if (state == B_WAIT) begin
          out_op  <= fetch_op;
          out_arg <= mem_rdata;
          out_pc  <= fetch_pc;
        end
`endif
      end
    end
  end
endmodule
